// File: rtl/sorteador_papeis_pkg.sv
// sorteador_papeis_pkg: shared state codes, LFSR constants and game-size defaults
package sorteador_papeis_pkg;
    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        SORTEIA = 3'd2,
        FIM     = 3'd3
    } estado_t;
    localparam int DB_W = 3;
    localparam logic [DB_W-1:0] DB_INVALIDO = 3'b111;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] SEED_SUBST = 16'hACE1;
    localparam int N_JOGADORES_PAD = 8;
    localparam int N_LOBOS_PAD = 2;
endpackage

// File: rtl/sorteador_papeis_if.sv
// sorteador_papeis_if: start/seed request and role-distribution result between control unit and dealer
interface sorteador_papeis_if #(
    parameter int N_JOGADORES = sorteador_papeis_pkg::N_JOGADORES_PAD
) ();
    import sorteador_papeis_pkg::*;
    logic                   inicia;
    logic [15:0]            seed;
    logic [N_JOGADORES-1:0] lobos;
    logic                   ocupado;
    logic                   pronto;
    logic [DB_W-1:0]        db_estado;
    modport master (output inicia, seed, input lobos, ocupado, pronto, db_estado);
    modport slave (input inicia, seed, output lobos, ocupado, pronto, db_estado);
endinterface

// File: rtl/sorteador_papeis_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR with load and step, a zero load becomes the substitute seed
module lfsr16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        carrega,
    input  logic [15:0] valor,
    input  logic        avanca,
    output logic [15:0] q
);
    import sorteador_papeis_pkg::*;
    // Load has priority over stepping; an all-zero state would lock up the LFSR
    always_ff @(posedge clock) begin
        if (reset) q <= '0;
        else if (carrega) q <= (valor == 16'h0000) ? SEED_SUBST : valor;
        else if (avanca) q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
endmodule

// File: rtl/sorteador_papeis.sv
// sorteador_papeis: draws N_LOBOS distinct wolf indices from a seeded LFSR, bounded by a fallback pick
module sorteador_papeis #(
    parameter int N_JOGADORES   = sorteador_papeis_pkg::N_JOGADORES_PAD,
    parameter int N_LOBOS       = sorteador_papeis_pkg::N_LOBOS_PAD,
    parameter int MAX_REJEICOES = 64
) (
    input logic clock,
    input logic reset,
    sorteador_papeis_if.slave bus
);
    import sorteador_papeis_pkg::*;
    localparam int IDX_W = $clog2(N_JOGADORES);
    localparam int EXT_W = 2 ** IDX_W;
    localparam int AW = $clog2(N_LOBOS + 1);
    localparam int RW = $clog2(MAX_REJEICOES + 1);
    localparam logic [IDX_W:0] LIM_JOG = (IDX_W + 1)'(N_JOGADORES);
    localparam logic [AW-1:0] ULT_ACEITO = AW'(N_LOBOS - 1);
    localparam logic [RW-1:0] LIM_REJ = RW'(MAX_REJEICOES - 1);
    localparam logic [N_JOGADORES-1:0] UM = N_JOGADORES'(1);

    estado_t                r_estado;
    logic [15:0]            r_seed;
    logic [N_JOGADORES-1:0] r_lobos;
    logic [AW-1:0]          r_aceitos;
    logic [RW-1:0]          r_rejeicoes;
    logic                   r_pronto;
    logic                   r_ocupado;
    logic [15:0]            w_lfsr;
    logic                   w_lfsr_unused;
    logic [IDX_W-1:0]       w_cand;
    logic [IDX_W-1:0]       w_livre;
    logic [IDX_W-1:0]       w_idx;
    logic [EXT_W-1:0]       w_lobos_ext;
    logic                   w_aceita;
    logic                   w_fallback;
    logic                   w_conta;

    lfsr16 u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .carrega (r_estado == CARREGA),
        .valor   (r_seed),
        .avanca  (r_estado == SORTEIA),
        .q       (w_lfsr)
    );

    assign w_cand = w_lfsr[IDX_W-1:0];
    assign w_lfsr_unused = ^w_lfsr[15:IDX_W];
    // Widened copy so out-of-range candidates can be looked up without a bounds hazard
    assign w_lobos_ext = EXT_W'(r_lobos);
    assign w_aceita = ({1'b0, w_cand} < LIM_JOG) && !w_lobos_ext[w_cand];
    assign w_fallback = !w_aceita && (r_rejeicoes == LIM_REJ);
    assign w_conta = w_aceita || w_fallback;
    assign w_idx = w_aceita ? w_cand : w_livre;

    // Lowest-index player not yet a wolf, used when too many draws were rejected in a row
    always_comb begin
        w_livre = '0;
        for (int i = N_JOGADORES - 1; i >= 0; i--) if (!r_lobos[i]) w_livre = i[IDX_W-1:0];
    end

    // Dealer FSM: ocupado and pronto are registered to reflect the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado    <= OCIOSO;
            r_seed      <= '0;
            r_lobos     <= '0;
            r_aceitos   <= '0;
            r_rejeicoes <= '0;
            r_pronto    <= 1'b0;
            r_ocupado   <= 1'b0;
        end else begin
            r_pronto  <= 1'b0;
            r_ocupado <= 1'b1;
            case (r_estado)
                OCIOSO: begin
                    r_ocupado <= bus.inicia;
                    if (bus.inicia) begin
                        r_seed   <= bus.seed;
                        r_estado <= CARREGA;
                    end
                end
                CARREGA: begin
                    r_lobos     <= '0;
                    r_aceitos   <= '0;
                    r_rejeicoes <= '0;
                    r_estado    <= SORTEIA;
                end
                SORTEIA: begin
                    if (w_conta) begin
                        r_lobos     <= r_lobos | (UM << w_idx);
                        r_aceitos   <= r_aceitos + 1'b1;
                        r_rejeicoes <= '0;
                        if (r_aceitos == ULT_ACEITO) begin
                            r_estado <= FIM;
                            r_pronto <= 1'b1;
                        end
                    end else begin
                        r_rejeicoes <= r_rejeicoes + 1'b1;
                    end
                end
                FIM: begin
                    r_estado  <= OCIOSO;
                    r_ocupado <= 1'b0;
                end
                default: begin
                    r_estado  <= OCIOSO;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lobos = r_lobos;
    assign bus.ocupado = r_ocupado;
    assign bus.pronto = r_pronto;
    assign bus.db_estado = (r_estado <= FIM) ? r_estado : DB_INVALIDO;
endmodule

// File: tb/tb_sorteador_papeis.sv
// tb_sorteador_papeis: three parameterisations driven together, checked against tables and a draw model
module tb_sorteador_papeis;
    logic        clk;
    logic        rst;
    logic        inicia;
    logic [15:0] seed;
    int          total;
    int          bad;

    sorteador_papeis_if #(.N_JOGADORES(8)) if0 ();
    sorteador_papeis_if #(.N_JOGADORES(6)) if1 ();
    sorteador_papeis_if #(.N_JOGADORES(8)) if2 ();

    sorteador_papeis u0 (.clock(clk), .reset(rst), .bus(if0.slave));
    sorteador_papeis #(.N_JOGADORES(6)) u1 (.clock(clk), .reset(rst), .bus(if1.slave));
    sorteador_papeis #(.MAX_REJEICOES(2)) u2 (.clock(clk), .reset(rst), .bus(if2.slave));

    assign if0.inicia = inicia;
    assign if1.inicia = inicia;
    assign if2.inicia = inicia;
    assign if0.seed = seed;
    assign if1.seed = seed;
    assign if2.seed = seed;

    logic [15:0] s_lob [3];
    logic        s_pr  [3];
    logic        s_oc  [3];
    logic [2:0]  s_db  [3];
    assign s_lob[0] = 16'(if0.lobos);
    assign s_lob[1] = 16'(if1.lobos);
    assign s_lob[2] = 16'(if2.lobos);
    assign s_pr[0] = if0.pronto;
    assign s_pr[1] = if1.pronto;
    assign s_pr[2] = if2.pronto;
    assign s_oc[0] = if0.ocupado;
    assign s_oc[1] = if1.ocupado;
    assign s_oc[2] = if2.ocupado;
    assign s_db[0] = if0.db_estado;
    assign s_db[1] = if1.db_estado;
    assign s_db[2] = if2.db_estado;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] seed;
        logic [15:0] lob [3];
        int          cic [3];
    } vet_t;

    logic [15:0] e_lob [3];
    int          e_cic [3];

    task automatic chk(input string nome, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    // Draw process straight from the rules: returns final wolf set and number of draw cycles
    function automatic void modelo(input int nj, input int nl, input int mr, input logic [15:0] s,
                                   output logic [15:0] lob, output int cic);
        logic [15:0] l;
        int acc, rej, c, w, livre;
        w = 0;
        while ((1 << w) < nj) w++;
        l = (s == 16'h0000) ? 16'hACE1 : s;
        lob = '0;
        acc = 0;
        rej = 0;
        cic = 0;
        while (acc < nl && cic < 10000) begin
            cic++;
            c = int'(l) % (1 << w);
            if (c < nj && !lob[c]) begin
                lob[c] = 1'b1;
                acc++;
                rej = 0;
            end else if (rej == mr - 1) begin
                livre = 0;
                while (lob[livre]) livre++;
                lob[livre] = 1'b1;
                acc++;
                rej = 0;
            end else begin
                rej++;
            end
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
    endfunction

    task automatic rodar(input logic [15:0] s, input int intrusa, input string tag);
        int prim [3];
        int npr [3];
        int noc [3];
        logic [15:0] lob_pr [3];
        logic [2:0] db_pr [3];
        int t;
        bit fim;
        for (int d = 0; d < 3; d++) begin
            prim[d] = -1;
            npr[d] = 0;
            noc[d] = 0;
            lob_pr[d] = '0;
            db_pr[d] = '0;
        end
        @(negedge clk);
        inicia = 1'b1;
        seed = s;
        @(posedge clk);
        #1;
        inicia = 1'b0;
        t = 0;
        fim = 1'b0;
        while (!fim && t < 400) begin
            for (int d = 0; d < 3; d++) begin
                if (s_oc[d]) noc[d]++;
                if (s_pr[d]) begin
                    npr[d]++;
                    if (prim[d] < 0) begin
                        prim[d] = t;
                        lob_pr[d] = s_lob[d];
                        db_pr[d] = s_db[d];
                    end
                end
            end
            fim = 1'b1;
            for (int d = 0; d < 3; d++) if (prim[d] < 0 || s_oc[d]) fim = 1'b0;
            if (t == intrusa) begin
                inicia = 1'b1;
                seed = 16'h0001;
            end
            @(posedge clk);
            #1;
            inicia = 1'b0;
            t++;
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s seed=%h d%0d lobos", tag, s, d), int'(lob_pr[d]), int'(e_lob[d]));
            chk($sformatf("%s seed=%h d%0d pronto_edge", tag, s, d), prim[d], e_cic[d] + 1);
            chk($sformatf("%s seed=%h d%0d pronto_len", tag, s, d), npr[d], 1);
            chk($sformatf("%s seed=%h d%0d ocupado_len", tag, s, d), noc[d], e_cic[d] + 2);
            chk($sformatf("%s seed=%h d%0d db_fim", tag, s, d), int'(db_pr[d]), 3);
            chk($sformatf("%s seed=%h d%0d lobos_hold", tag, s, d), int'(s_lob[d]), int'(e_lob[d]));
        end
    endtask

    vet_t tab [4];

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        inicia = 1'b0;
        seed = '0;
        tab[0].seed = 16'h0001; tab[0].lob = '{16'h06, 16'h06, 16'h06}; tab[0].cic = '{2, 2, 2};
        tab[1].seed = 16'h0000; tab[1].lob = '{16'h0A, 16'h0A, 16'h0A}; tab[1].cic = '{2, 2, 2};
        tab[2].seed = 16'h0008; tab[2].lob = '{16'h03, 16'h03, 16'h03}; tab[2].cic = '{9, 9, 3};
        tab[3].seed = 16'h0007; tab[3].lob = '{16'hC0, 16'h11, 16'hC0}; tab[3].cic = '{2, 4, 2};
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset d%0d lobos", d), int'(s_lob[d]), 0);
            chk($sformatf("reset d%0d pronto", d), int'(s_pr[d]), 0);
            chk($sformatf("reset d%0d ocupado", d), int'(s_oc[d]), 0);
            chk($sformatf("reset d%0d estado", d), int'(s_db[d]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e_lob = tab[i].lob;
            e_cic = tab[i].cic;
            rodar(tab[i].seed, -1, "tab");
        end
        e_lob = tab[2].lob;
        e_cic = tab[2].cic;
        rodar(16'h0008, 3, "intrusa");
        @(negedge clk);
        inicia = 1'b1;
        seed = 16'h0008;
        @(posedge clk);
        #1;
        inicia = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("abort d%0d estado", d), int'(s_db[d]), 0);
            chk($sformatf("abort d%0d lobos", d), int'(s_lob[d]), 0);
            chk($sformatf("abort d%0d ocupado", d), int'(s_oc[d]), 0);
            chk($sformatf("abort d%0d pronto", d), int'(s_pr[d]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        begin
            int npr_pos [3];
            npr_pos = '{0, 0, 0};
            repeat (15) begin
                @(posedge clk);
                #1;
                for (int d = 0; d < 3; d++) if (s_pr[d] || s_oc[d]) npr_pos[d]++;
            end
            for (int d = 0; d < 3; d++) chk($sformatf("abort d%0d quiet", d), npr_pos[d], 0);
        end
        for (int i = 0; i < 25; i++) begin
            logic [15:0] s;
            s = 16'($urandom);
            modelo(8, 2, 64, s, e_lob[0], e_cic[0]);
            modelo(6, 2, 64, s, e_lob[1], e_cic[1]);
            modelo(8, 2, 2, s, e_lob[2], e_cic[2]);
            rodar(s, -1, "rand");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
